// File: rtl/accumulator_control_sequencer.sv
// Fetch-decode-execute controller for the 16-bit accumulator machine.
// Owns PC, IR, MAR, MBR and AC and drives a single-port memory with a
// synchronous write and a registered, one-cycle-latency read.
module accumulator_control_sequencer #(
   parameter int unsigned        ADDR_W   = 12,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   input  logic [15:0]       mem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       ir,
   output logic [15:0]       ac,
   output logic [15:0]       mbr,
   output logic [3:0]        state,
   output logic              halted
);

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned STATE_W = 4;

   localparam logic [OP_W-1:0] OP_LOAD  = 4'h1;
   localparam logic [OP_W-1:0] OP_STORE = 4'h2;
   localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
   localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
   localparam logic [OP_W-1:0] OP_HALT  = 4'h7;
   localparam logic [OP_W-1:0] OP_SKIP  = 4'h8;
   localparam logic [OP_W-1:0] OP_JUMP  = 4'h9;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH0 = 4'd0,
      S_FETCH1 = 4'd1,
      S_FETCH2 = 4'd2,
      S_DECODE = 4'd3,
      S_RD0    = 4'd4,
      S_RD1    = 4'd5,
      S_EXEC   = 4'd6,
      S_WR     = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   state_t              state_q;
   state_t              state_next;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   mar_q;
   logic [DATA_W-1:0]   ir_q;
   logic [DATA_W-1:0]   mbr_q;
   logic [DATA_W-1:0]   ac_q;

   logic [OP_W-1:0]     opcode;
   logic [ADDR_W-1:0]   operand;
   logic [ADDR_W-1:0]   pc_inc;
   logic                is_load;
   logic                is_store;
   logic                is_add;
   logic                is_sub;
   logic                is_halt;
   logic                is_skip;
   logic                is_jump;
   logic                is_read;
   logic                skip_taken;

   // Instruction field split and opcode decode from the held IR
   always_comb begin
      opcode   = ir_q[DATA_W-1 -: OP_W];
      operand  = ir_q[ADDR_W-1:0];
      pc_inc   = pc_q + ADDR_W'(1);
      is_load  = (opcode == OP_LOAD);
      is_store = (opcode == OP_STORE);
      is_add   = (opcode == OP_ADD);
      is_sub   = (opcode == OP_SUB);
      is_halt  = (opcode == OP_HALT);
      is_skip  = (opcode == OP_SKIP);
      is_jump  = (opcode == OP_JUMP);
      is_read  = is_load | is_add | is_sub;
   end

   // SKIPCOND condition: IR[11:10] selects the test on signed AC
   always_comb begin
      skip_taken = 1'b0;
      case (ir_q[11:10])
         2'b00:   skip_taken = ac_q[DATA_W-1];
         2'b01:   skip_taken = (ac_q == '0);
         2'b10:   skip_taken = !ac_q[DATA_W-1] && (ac_q != '0);
         default: skip_taken = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH0;
      end else begin
         state_q <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_q;
      case (state_q)
         S_FETCH0: state_next = S_FETCH1;
         S_FETCH1: state_next = S_FETCH2;
         S_FETCH2: state_next = S_DECODE;
         S_DECODE: begin
            if (is_halt) begin
               state_next = S_HALT;
            end else if (is_read) begin
               state_next = S_RD0;
            end else if (is_store) begin
               state_next = S_WR;
            end else begin
               state_next = S_FETCH0;
            end
         end
         S_RD0:    state_next = S_RD1;
         S_RD1:    state_next = S_EXEC;
         S_EXEC:   state_next = S_FETCH0;
         S_WR:     state_next = S_FETCH0;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_FETCH0;
      endcase
   end

   // State-decoded outputs; mem_we drops as soon as reset forces FETCH0
   always_comb begin
      mem_we = 1'b0;
      halted = 1'b0;
      case (state_q)
         S_WR:    mem_we = 1'b1;
         S_HALT:  halted = 1'b1;
         default: begin
            mem_we = 1'b0;
            halted = 1'b0;
         end
      endcase
   end

   // Datapath registers; each state updates only the registers it names
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_PC;
         mar_q <= '0;
         ir_q  <= '0;
         mbr_q <= '0;
         ac_q  <= '0;
      end else begin
         case (state_q)
            S_FETCH0: mar_q <= pc_q;
            S_FETCH2: begin
               ir_q <= mem_rdata;
               pc_q <= pc_inc;
            end
            S_DECODE: begin
               mar_q <= operand;
               if (is_jump) begin
                  pc_q <= operand;
               end else if (is_skip && skip_taken) begin
                  pc_q <= pc_inc;
               end
            end
            S_RD1:    mbr_q <= mem_rdata;
            S_EXEC: begin
               if (is_load) begin
                  ac_q <= mbr_q;
               end else if (is_add) begin
                  ac_q <= DATA_W'(ac_q + mbr_q);
               end else if (is_sub) begin
                  ac_q <= DATA_W'(ac_q - mbr_q);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Memory port and debug views of the internal registers
   assign mem_addr  = mar_q;
   assign mem_wdata = ac_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign ac        = ac_q;
   assign mbr       = mbr_q;
   assign state     = state_q;

endmodule

// File: doc/accumulator_control_sequencer.md
Name: accumulator_control_sequencer

Overview:
- Fetch-decode-execute controller for the 16-bit accumulator machine.
- Acts as the initiator on the main-memory port. The single-port memory is the responder: synchronous write, registered read, 1-cycle read latency.
- Owns PC, IR, MAR, MBR and AC.
- Exposes those registers for debug and drives the memory address, write-data and write-enable lines.

Parameters:
- ADDR_W, 12, word-address width; equals the IR operand field width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- mem_addr  out  ADDR_W  memory word address; always equals MAR.
- mem_wdata  out  16  write data; always equals AC.
- mem_we  out  1  write enable; high only in state WR.
- mem_rdata  in  16  memory read data; valid the cycle after the address was presented with mem_we=0.
- pc  out  ADDR_W  program counter.
- ir  out  16  instruction register.
- ac  out  16  accumulator.
- mbr  out  16  memory buffer register.
- state  out  4  current FSM state encoding, for debug.
- halted  out  1  high while in state HALT.

Behaviour:
- Reset (asynchronous, reset=0):
  - PC=RESET_PC; IR=MAR=MBR=AC=0; state=FETCH0.
  - mem_we=0 immediately, because mem_we decodes combinationally from state.
  - Reset asserted mid-operation aborts any access; no write occurs after reset assertion.
  - First posedge with reset=1 executes FETCH0.
- Instruction format: [15:12] opcode, [11:0] operand address X.
- Opcodes:
  - 1 LOAD: AC=M[X].
  - 2 STORE: M[X]=AC.
  - 3 ADD: AC=AC+M[X].
  - 4 SUB: AC=AC-M[X].
  - 7 HALT.
  - 8 SKIPCOND.
  - 9 JUMP: PC=X.
  - All other opcodes: NOP.
- FSM states and actions:
  - FETCH0: MAR<=PC. Next: FETCH1.
  - FETCH1: memory samples MAR with mem_we=0. Next: FETCH2.
  - FETCH2: IR<=mem_rdata; PC<=PC+1, wrapping modulo 2^ADDR_W (max address -> 0). Next: DECODE.
  - DECODE:
    - MAR<=IR[11:0].
    - JUMP: PC<=IR[11:0], then FETCH0.
    - SKIPCOND: evaluate condition; if true PC<=PC+1 (wrapping); then FETCH0.
    - HALT: go to HALT.
    - LOAD/ADD/SUB: go to RD0.
    - STORE: go to WR.
    - NOP: go to FETCH0.
  - RD0: memory samples MAR. Next: RD1.
  - RD1: MBR<=mem_rdata. Next: EXEC.
  - EXEC:
    - LOAD: AC<=MBR.
    - ADD: AC<=AC+MBR.
    - SUB: AC<=AC-MBR.
    - Arithmetic is modulo 2^16; no flags.
    - Next: FETCH0.
  - WR: mem_we=1, mem_addr=MAR, mem_wdata=AC for exactly one cycle. Next: FETCH0.
  - HALT: absorbing; all registers hold; mem_we=0; halted=1. Exit only via reset.
- SKIPCOND condition from IR[11:10], AC treated as two's complement:
  - 00: skip if AC<0.
  - 01: skip if AC==0.
  - 10: skip if AC>0.
  - 11: never skip.
  - IR[9:0] is ignored.
- Cycles per instruction, FETCH0 to the next FETCH0:
  - LOAD/ADD/SUB: 7.
  - STORE: 5.
  - JUMP/SKIPCOND/NOP: 4.
  - HALT is reached 4 cycles after FETCH0.
- mem_we is never asserted in any state other than WR.
- Self-modifying code is permitted: a STORE to the address of the next instruction is visible to the following fetch, because the write completes before FETCH1.
- Registers not named in a state's action hold their value.

Test Plan:
- Reset mid-STORE: assert reset=0 during WR with AC=0xBEEF, X=0x020 -> mem_we falls to 0 without waiting for a clock edge; M[0x020] is unchanged; PC=0, AC=0, state=FETCH0.
- LOAD/ADD/STORE/HALT:
  - Setup: M[0]=0x1010, M[1]=0x3011, M[2]=0x2012, M[3]=0x7000, M[0x10]=0x0005, M[0x11]=0x0007.
  - Required: M[0x12]=0x000C, AC=0x000C, halted=1, PC=4.
  - halted rises exactly 7+7+5+4=23 cycles after reset release.
- SUB wrap:
  - Setup: AC loaded with 0x0000, then SUB from a location holding 0x0001.
  - Required: AC=0xFFFF.
  - SKIPCOND 0x8000 then skips (PC advances by 2 total); SKIPCOND 0x8400 does not skip.
- JUMP and PC wrap:
  - JUMP: 0x9FFF at address 0 -> next fetch address is 0xFFF.
  - PC wrap: instruction at 0xFFF is a NOP (0x0000) -> the following fetch is at address 0x000.
- HALT hold: after halted=1, run 50 cycles -> pc, ir, ac and mbr are unchanged and mem_we stays 0 throughout.
- Write-port check: for every STORE, mem_we is high for exactly 1 cycle with mem_addr=X and mem_wdata=AC; no mem_we pulses occur during LOAD/ADD/SUB/JUMP.
